// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing one FIFO write port among NUM_REQ valid/ready producers.
// Optional burst lock (up to MAX_BURST beats per grant) is enabled by defining FIFO_ARB_BURST_EN.
module fifo_wr_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 8,
  parameter int MAX_BURST  = 4,
  localparam int GW        = $clog2(NUM_REQ)
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]            req_ready,
  output logic                          fifo_wr_en,
  output logic [DATA_WIDTH-1:0]         fifo_data_in,
  input  logic                          fifo_full,
  output logic                          grant_valid,
  output logic [GW-1:0]                 grant_id
);

  logic [GW-1:0] ptr_r;
  logic [GW-1:0] rr_winner_s;
  logic          rr_found_s;
  logic [GW:0]   cand_s;
  logic [GW-1:0] winner_s;
  logic          grant_raw_s;
  logic          accept_s;

  function automatic logic [GW-1:0] next_idx(input logic [GW-1:0] idx);
    logic [GW-1:0] nxt;
    if (idx == GW'(NUM_REQ - 1)) begin
      nxt = '0;
    end else begin
      nxt = idx + GW'(1);
    end
    return nxt;
  endfunction

  // Round-robin search starting at ptr_r; the GW+1 bit candidate never exceeds 2*NUM_REQ-2
  always_comb begin
    rr_found_s  = 1'b0;
    rr_winner_s = '0;
    cand_s      = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      cand_s = {1'b0, ptr_r} + (GW+1)'(i);
      if (cand_s >= (GW+1)'(NUM_REQ)) begin
        cand_s = cand_s - (GW+1)'(NUM_REQ);
      end else begin
        cand_s = cand_s;
      end
      if (!rr_found_s && req_valid[cand_s[GW-1:0]]) begin
        rr_found_s  = 1'b1;
        rr_winner_s = cand_s[GW-1:0];
      end else begin
        rr_found_s  = rr_found_s;
        rr_winner_s = rr_winner_s;
      end
    end
  end

`ifdef FIFO_ARB_BURST_EN
  localparam int BW = $clog2(MAX_BURST + 1);

  typedef enum logic {IDLE, LOCK} state_t;

  state_t        state_r;
  logic [GW-1:0] owner_r;
  logic [BW-1:0] beat_cnt_r;

  // While locked only the owner can be granted; otherwise use the round-robin result
  always_comb begin
    if (state_r == LOCK) begin
      winner_s    = owner_r;
      grant_raw_s = req_valid[owner_r];
    end else begin
      winner_s    = rr_winner_s;
      grant_raw_s = rr_found_s;
    end
  end

  assign accept_s = grant_raw_s & ~fifo_full;

  // Burst FSM: lock on the first accepted beat, release on MAX_BURST beats or owner drop
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r    <= IDLE;
      ptr_r      <= '0;
      owner_r    <= '0;
      beat_cnt_r <= '0;
    end else begin
      case (state_r)
        IDLE: begin
          if (accept_s) begin
            if (MAX_BURST == 1) begin
              ptr_r <= next_idx(winner_s);
            end else begin
              state_r    <= LOCK;
              owner_r    <= winner_s;
              beat_cnt_r <= BW'(1);
            end
          end
        end
        LOCK: begin
          if (fifo_full) begin
            state_r <= LOCK;
          end else if (!req_valid[owner_r]) begin
            state_r    <= IDLE;
            ptr_r      <= next_idx(owner_r);
            beat_cnt_r <= '0;
          end else if (beat_cnt_r + BW'(1) == BW'(MAX_BURST)) begin
            state_r    <= IDLE;
            ptr_r      <= next_idx(owner_r);
            beat_cnt_r <= '0;
          end else begin
            beat_cnt_r <= beat_cnt_r + BW'(1);
          end
        end
        default: begin
          state_r    <= IDLE;
          beat_cnt_r <= '0;
        end
      endcase
    end
  end
`else
  assign winner_s    = rr_winner_s;
  assign grant_raw_s = rr_found_s;
  assign accept_s    = grant_raw_s & ~fifo_full;

  // Per-beat round robin: move priority just past the accepted requester
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_r <= '0;
    end else if (accept_s) begin
      ptr_r <= next_idx(winner_s);
    end else begin
      ptr_r <= ptr_r;
    end
  end
`endif

  // Zero-latency write-port and handshake outputs; reset blanks everything immediately
  always_comb begin
    grant_valid  = 1'b0;
    grant_id     = '0;
    fifo_data_in = '0;
    fifo_wr_en   = 1'b0;
    req_ready    = '0;
    if (rst) begin
      grant_valid = 1'b0;
    end else if (grant_raw_s) begin
      grant_valid  = 1'b1;
      grant_id     = winner_s;
      fifo_data_in = req_data[int'(winner_s)*DATA_WIDTH +: DATA_WIDTH];
      fifo_wr_en   = accept_s;
      if (accept_s) begin
        req_ready = NUM_REQ'(1) << winner_s;
      end else begin
        req_ready = '0;
      end
    end else begin
      grant_valid = 1'b0;
    end
  end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed self-checking bench for fifo_wr_arbiter, with a small registered-full FIFO model.
module tb_fifo_wr_arbiter;
  localparam int N  = 4;
  localparam int DW = 8;
`ifdef FIFO_ARB_BURST_EN
  localparam int BURST = 4;
`else
  localparam int BURST = 1;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic [N-1:0]  req_valid;
  logic [N*DW-1:0] req_data;
  logic [N-1:0]  req_ready;
  logic          fifo_wr_en;
  logic [DW-1:0] fifo_data_in;
  logic          fifo_full;
  logic          tb_full;
  logic          use_fifo;
  logic          grant_valid;
  logic [1:0]    grant_id;

  int vectors = 0;
  int errors  = 0;

  logic [DW-1:0] mf_mem [8];
  logic [3:0]    mf_cnt;
  logic [2:0]    mf_wp, mf_rp;
  logic          mf_rd;
  logic          mf_full;
  logic          mf_wr_fire, mf_rd_fire;

  always #5 clk = ~clk;

  fifo_wr_arbiter #(.NUM_REQ(N), .DATA_WIDTH(DW), .MAX_BURST(4)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_data(req_data),
    .req_ready(req_ready), .fifo_wr_en(fifo_wr_en), .fifo_data_in(fifo_data_in),
    .fifo_full(fifo_full), .grant_valid(grant_valid), .grant_id(grant_id)
  );

  // Reference FIFO of depth 8 whose full flag comes straight from a register
  assign mf_full    = (mf_cnt == 4'd8);
  assign mf_wr_fire = use_fifo && fifo_wr_en && (mf_cnt != 4'd8);
  assign mf_rd_fire = mf_rd && (mf_cnt != 4'd0);
  assign fifo_full  = use_fifo ? mf_full : tb_full;

  always @(posedge clk) begin
    if (rst) begin
      mf_cnt <= 4'd0;
      mf_wp  <= 3'd0;
      mf_rp  <= 3'd0;
    end else begin
      if (mf_wr_fire) begin
        mf_mem[mf_wp] <= fifo_data_in;
        mf_wp <= mf_wp + 3'd1;
      end
      if (mf_rd_fire) mf_rp <= mf_rp + 3'd1;
      mf_cnt <= mf_cnt + 4'(mf_wr_fire) - 4'(mf_rd_fire);
    end
  end

  task automatic set_data();
    for (int i = 0; i < N; i++) req_data[i*DW +: DW] = 8'(8'h10 + i);
  endtask

  task automatic apply_reset();
    rst = 1'b1; req_valid = 4'b0000; tb_full = 1'b0; use_fifo = 1'b0; mf_rd = 1'b0;
    set_data();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; req_valid = 4'b1111; tb_full = 1'b0; use_fifo = 1'b0; mf_rd = 1'b0;
    set_data();
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      vectors++;
      if ({fifo_wr_en, req_ready, grant_valid, grant_id} !== 8'h00) begin
        errors++;
        $display("FAIL reset_outputs cycle %0d: got wr=%b ready=%b gv=%b id=%0d, want all 0",
                 c, fifo_wr_en, req_ready, grant_valid, grant_id);
      end
      @(posedge clk);
    end
    #1 rst = 1'b0;
    @(negedge clk);
    vectors++;
    if ({grant_valid, grant_id, fifo_wr_en} !== {1'b1, 2'd0, 1'b1}) begin
      errors++;
      $display("FAIL reset_first_grant: got gv=%b id=%0d wr=%b, want gv=1 id=0 wr=1",
               grant_valid, grant_id, fifo_wr_en);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_round_robin();
    int e;
    apply_reset();
    req_valid = 4'b1111;
    for (int k = 0; k < 8; k++) begin
      e = (k / BURST) % N;
      @(negedge clk);
      vectors++;
      if ({fifo_wr_en, grant_id, fifo_data_in, req_ready} !== {1'b1, 2'(e), 8'(8'h10 + e), 4'(1 << e)}) begin
        errors++;
        $display("FAIL round_robin beat %0d: got wr=%b id=%0d data=%h ready=%b, want wr=1 id=%0d data=%h ready=%b",
                 k, fifo_wr_en, grant_id, fifo_data_in, req_ready, e, 8'(8'h10 + e), 4'(1 << e));
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_sparse();
    int e;
    int n;
    apply_reset();
    req_valid = 4'b1010;
    n = (BURST == 1) ? 5 : 8;
    for (int k = 0; k < n; k++) begin
      e = (((k / BURST) % 2) == 1) ? 3 : 1;
      @(negedge clk);
      vectors++;
      if ({fifo_wr_en, grant_id} !== {1'b1, 2'(e)}) begin
        errors++;
        $display("FAIL sparse beat %0d: got wr=%b id=%0d, want wr=1 id=%0d", k, fifo_wr_en, grant_id, e);
      end
      @(posedge clk); #1;
    end
`ifndef FIFO_ARB_BURST_EN
    // pointer now sits at 2, so req0 must wait behind req3
    req_valid = 4'b1011;
    @(negedge clk);
    vectors++;
    if ({fifo_wr_en, grant_id} !== {1'b1, 2'd3}) begin
      errors++;
      $display("FAIL sparse_raise_req0_first: got wr=%b id=%0d, want wr=1 id=3", fifo_wr_en, grant_id);
    end
    @(posedge clk); #1;
    @(negedge clk);
    vectors++;
    if ({fifo_wr_en, grant_id, fifo_data_in} !== {1'b1, 2'd0, 8'h10}) begin
      errors++;
      $display("FAIL sparse_raise_req0_second: got wr=%b id=%0d data=%h, want wr=1 id=0 data=10",
               fifo_wr_en, grant_id, fifo_data_in);
    end
    @(posedge clk); #1;
`endif
  endtask

  task automatic test_back_pressure();
    int writes;
    writes = 0;
    apply_reset();
    req_valid = 4'b0100;
    req_data[2*DW +: DW] = 8'hA5;
    tb_full = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      if (fifo_wr_en) writes++;
      vectors++;
      if ({fifo_wr_en, req_ready, grant_valid, grant_id, fifo_data_in} !== {1'b0, 4'b0000, 1'b1, 2'd2, 8'hA5}) begin
        errors++;
        $display("FAIL backpressure_hold cycle %0d: got wr=%b ready=%b gv=%b id=%0d data=%h, want wr=0 ready=0000 gv=1 id=2 data=a5",
                 c, fifo_wr_en, req_ready, grant_valid, grant_id, fifo_data_in);
      end
      @(posedge clk); #1;
    end
    tb_full = 1'b0;
    @(negedge clk);
    if (fifo_wr_en) writes++;
    vectors++;
    if ({fifo_wr_en, req_ready, fifo_data_in} !== {1'b1, 4'b0100, 8'hA5}) begin
      errors++;
      $display("FAIL backpressure_release: got wr=%b ready=%b data=%h, want wr=1 ready=0100 data=a5",
               fifo_wr_en, req_ready, fifo_data_in);
    end
    @(posedge clk); #1;
    req_valid = 4'b0000;
    repeat (2) begin
      @(negedge clk);
      if (fifo_wr_en) writes++;
      @(posedge clk); #1;
    end
    vectors++;
    if (writes !== 1) begin
      errors++;
      $display("FAIL backpressure_write_count: got %0d writes, want 1", writes);
    end
  endtask

  task automatic test_real_fifo();
    int sent;
    int popped;
    logic acc;
    apply_reset();
    use_fifo = 1'b1;
    sent = 0;
    popped = 0;
    for (int c = 0; c < 12; c++) begin
      req_valid = {3'b000, (sent < 10)};
      req_data[0 +: DW] = 8'(8'hC0 + sent);
      @(negedge clk);
      acc = req_ready[0];
      @(posedge clk); #1;
      if (acc) sent++;
    end
    vectors++;
    if (sent !== 8) begin
      errors++;
      $display("FAIL fifo_fill_count: got %0d accepted, want 8", sent);
    end
    @(negedge clk);
    vectors++;
    if ({fifo_full, fifo_wr_en, req_ready} !== {1'b1, 1'b0, 4'b0000}) begin
      errors++;
      $display("FAIL fifo_full_stall: got full=%b wr=%b ready=%b, want full=1 wr=0 ready=0000",
               fifo_full, fifo_wr_en, req_ready);
    end
    @(posedge clk); #1;
    mf_rd = 1'b1;
    for (int c = 0; c < 40 && popped < 10; c++) begin
      req_valid = {3'b000, (sent < 10)};
      req_data[0 +: DW] = 8'(8'hC0 + sent);
      @(negedge clk);
      acc = req_ready[0];
      if (mf_cnt != 4'd0) begin
        vectors++;
        if (mf_mem[mf_rp] !== 8'(8'hC0 + popped)) begin
          errors++;
          $display("FAIL fifo_drain_word %0d: got %h, want %h", popped, mf_mem[mf_rp], 8'(8'hC0 + popped));
        end
        popped++;
      end
      @(posedge clk); #1;
      if (acc) sent++;
    end
    vectors++;
    if (popped !== 10 || sent !== 10) begin
      errors++;
      $display("FAIL fifo_drain_total: got popped=%0d sent=%0d, want 10 and 10", popped, sent);
    end
    mf_rd = 1'b0;
    use_fifo = 1'b0;
    req_valid = 4'b0000;
  endtask

  task automatic test_reset_mid();
    int e;
    apply_reset();
    req_valid = 4'b1111;
    for (int k = 0; k < 2; k++) begin
      e = (k / BURST) % N;
      @(negedge clk);
      vectors++;
      if ({fifo_wr_en, grant_id} !== {1'b1, 2'(e)}) begin
        errors++;
        $display("FAIL reset_mid_pre beat %0d: got wr=%b id=%0d, want wr=1 id=%0d", k, fifo_wr_en, grant_id, e);
      end
      @(posedge clk); #1;
    end
    rst = 1'b1;
    @(negedge clk);
    vectors++;
    if ({fifo_wr_en, req_ready, grant_valid, grant_id, fifo_data_in} !== 16'h0000) begin
      errors++;
      $display("FAIL reset_mid_outputs: got wr=%b ready=%b gv=%b id=%0d data=%h, want all 0",
               fifo_wr_en, req_ready, grant_valid, grant_id, fifo_data_in);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    for (int k = 0; k < 5; k++) begin
      e = (k / BURST) % N;
      @(negedge clk);
      vectors++;
      if ({fifo_wr_en, grant_id} !== {1'b1, 2'(e)}) begin
        errors++;
        $display("FAIL reset_mid_post beat %0d: got wr=%b id=%0d, want wr=1 id=%0d", k, fifo_wr_en, grant_id, e);
      end
      @(posedge clk); #1;
    end
  endtask

`ifdef FIFO_ARB_BURST_EN
  task automatic test_burst();
    int e;
    apply_reset();
    req_valid = 4'b0011;
    for (int k = 0; k < 12; k++) begin
      e = (k / 4) % 2;
      @(negedge clk);
      vectors++;
      if ({fifo_wr_en, grant_id} !== {1'b1, 2'(e)}) begin
        errors++;
        $display("FAIL burst beat %0d: got wr=%b id=%0d, want wr=1 id=%0d", k, fifo_wr_en, grant_id, e);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_burst_release();
    apply_reset();
    req_valid = 4'b0011;
    repeat (2) begin
      @(negedge clk);
      vectors++;
      if ({fifo_wr_en, grant_id} !== {1'b1, 2'd0}) begin
        errors++;
        $display("FAIL burst_release_pre: got wr=%b id=%0d, want wr=1 id=0", fifo_wr_en, grant_id);
      end
      @(posedge clk); #1;
    end
    req_valid = 4'b0010;
    @(negedge clk);
    vectors++;
    if ({fifo_wr_en, grant_valid, req_ready} !== 6'b000000) begin
      errors++;
      $display("FAIL burst_release_bubble: got wr=%b gv=%b ready=%b, want all 0", fifo_wr_en, grant_valid, req_ready);
    end
    @(posedge clk); #1;
    @(negedge clk);
    vectors++;
    if ({fifo_wr_en, grant_id, req_ready} !== {1'b1, 2'd1, 4'b0010}) begin
      errors++;
      $display("FAIL burst_release_next: got wr=%b id=%0d ready=%b, want wr=1 id=1 ready=0010",
               fifo_wr_en, grant_id, req_ready);
    end
    @(posedge clk); #1;
  endtask
`endif

  initial begin
    test_reset();
    test_round_robin();
    test_sparse();
    test_back_pressure();
    test_real_fifo();
    test_reset_mid();
`ifdef FIFO_ARB_BURST_EN
    test_burst();
    test_burst_release();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
